vid_timing_gen: RTL

//  Video stream source: generates raster timing (vs/hs/de) plus a 24-bit RGB test pattern.

---
 rtl/vid_timing_gen_pkg.sv | 46 ++++
 rtl/vid_timing_gen_pattern_gen.sv | 44 ++++
 rtl/vid_timing_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vid_timing_gen_pkg.sv
// vid_timing_gen_pkg: timing presets, pattern codes and colour-bar table shared by the video source
package vid_timing_gen_pkg;
    localparam int CNT_W = 11;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int HD_H_ACTIVE  = 1280;
    localparam int HD_H_FP      = 110;
    localparam int HD_H_SYNC    = 40;
    localparam int HD_H_BP      = 220;
    localparam int HD_V_ACTIVE  = 720;
    localparam int HD_V_FP      = 5;
    localparam int HD_V_SYNC    = 5;
    localparam int HD_V_BP      = 20;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_RAMP    = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction
endpackage

// File: rtl/vid_timing_gen_pattern_gen.sv
// vid_pattern_gen: RGB test-pattern colour for the current raster position
module vid_pattern_gen
    import vid_timing_gen_pkg::*;
#(
    parameter int          H_ACTIVE    = VGA_H_ACTIVE,
    parameter logic [23:0] SOLID_COLOR = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        wrap,
    input  logic [7:0]  x,
    input  logic        y5,
    input  pat_e        pat,
    output logic [23:0] rgb
);
    localparam int BW = H_ACTIVE / 8;

    logic [2:0]       bar;
    logic [CNT_W-1:0] col;

    // Bar index tracks x without a divider; it parks on the black bar for any remainder columns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar <= '0;
            col <= '0;
        end else if (!step || wrap) begin
            bar <= '0;
            col <= '0;
        end else if (col == CNT_W'(BW - 1) && bar != 3'd7) begin
            bar <= bar + 3'd1;
            col <= '0;
        end else begin
            col <= col + 1'b1;
        end
    end

    // Colour for the latched pattern at this pixel
    always_comb begin
        rgb = pat == PAT_BARS    ? bar_rgb(bar) :
              pat == PAT_CHECKER ? ((x[5] ^ y5) ? 24'hFFFFFF : 24'h000000) :
              pat == PAT_RAMP    ? {3{x}} : SOLID_COLOR;
    end
endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing (vs/hs/de) and RGB test-pattern source with frame-aligned start/stop
module vid_timing_gen
    import vid_timing_gen_pkg::*;
#(
    parameter int          H_ACTIVE    = VGA_H_ACTIVE,
    parameter int          H_FP        = VGA_H_FP,
    parameter int          H_SYNC      = VGA_H_SYNC,
    parameter int          H_BP        = VGA_H_BP,
    parameter int          V_ACTIVE    = VGA_V_ACTIVE,
    parameter int          V_FP        = VGA_V_FP,
    parameter int          V_SYNC      = VGA_V_SYNC,
    parameter int          V_BP        = VGA_V_BP,
    parameter logic        SYNC_POL    = 1'b0,
    parameter logic [23:0] SOLID_COLOR = 24'hFF00FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        pattern_sel,
    output logic              vs_o,
    output logic              hs_o,
    output logic              de_o,
    output logic [23:0]       data_o,
    output logic [CNT_W-1:0]  x_o,
    output logic [CNT_W-1:0]  y_o,
    output logic              sof_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
        $error("vid_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
    end

    state_e           state, state_nxt;
    pat_e             pat;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [23:0]      rgb;
    logic             run, h_last, v_last, active;

    assign run    = state != ST_IDLE;
    assign h_last = h_cnt == H_LAST;
    assign v_last = v_cnt == V_LAST;
    assign active = h_cnt < H_ACT && v_cnt < V_ACT;

    // en is acted on only at line ends, and stopping only happens on the last line so frames stay whole
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE)
            state_nxt = en ? ST_RUN : ST_IDLE;
        else if (h_last)
            state_nxt = en ? ST_RUN : v_last ? ST_IDLE : ST_DRAIN;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Raster counters; parked at 0 while idle so a restart begins a fresh frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
    end

    // Pattern changes only between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pat <= PAT_BARS;
        else if ((!run && en) || (run && h_last && v_last)) pat <= pat_e'(pattern_sel);
    end

    vid_pattern_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .SOLID_COLOR (SOLID_COLOR)
    ) u_pat (
        .clk  (clk),
        .rst  (rst),
        .step (run),
        .wrap (h_last),
        .x    (h_cnt[7:0]),
        .y5   (v_cnt[5]),
        .pat  (pat),
        .rgb  (rgb)
    );

    // All outputs registered together one clock behind the counters; idle holds reset values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_o   <= ~SYNC_POL;
            vs_o   <= ~SYNC_POL;
            de_o   <= 1'b0;
            data_o <= '0;
            x_o    <= '0;
            y_o    <= '0;
            sof_o  <= 1'b0;
        end else begin
            hs_o   <= run && h_cnt >= HS_BEG && h_cnt < HS_END ? SYNC_POL : ~SYNC_POL;
            vs_o   <= run && v_cnt >= VS_BEG && v_cnt < VS_END ? SYNC_POL : ~SYNC_POL;
            de_o   <= run && active;
            data_o <= run && active ? rgb : '0;
            x_o    <= run ? h_cnt : '0;
            y_o    <= run ? v_cnt : '0;
            sof_o  <= run && h_cnt == '0 && v_cnt == '0;
        end
    end
endmodule
